// File: rtl/ide_req_pkg.sv
// ide_req_pkg: request codes, register map, FSM states and header layout shared by the IDE request server
package ide_req_pkg;

    localparam logic [2:0] REQ_NONE = 3'd0;
    localparam logic [2:0] REQ_CMD  = 3'd1;
    localparam logic [2:0] REQ_DIN  = 3'd2;
    localparam logic [2:0] REQ_DOUT = 3'd3;

    localparam logic [3:0] REG_DATA    = 4'd0;
    localparam logic [3:0] REG_TF_BASE = 4'd1;
    localparam logic [3:0] REG_STATUS  = 4'd7;

    localparam int HDR_PORT  = 15;
    localparam int HDR_CODE  = 12;
    localparam int HDR_CNT_W = 12;

    typedef enum logic [3:0] {
        S_IDLE, S_ARB, S_HDR, S_RD_ISSUE, S_RD_CAP, S_RD_HOLD,
        S_WR_WAIT, S_WR_ISSUE, S_STAT_WAIT, S_STAT_ISSUE, S_GAP
    } state_t;

    function automatic logic [15:0] hdr_word(input logic port, input logic [2:0] code,
                                             input logic [HDR_CNT_W-1:0] count);
        logic [15:0] h;
        h = '0;
        h[HDR_PORT] = port;
        h[HDR_CODE +: 3] = code;
        h[HDR_CNT_W-1:0] = count;
        return h;
    endfunction

    function automatic logic [3:0] first_reg(input logic [2:0] code);
        return code == REQ_CMD ? REG_TF_BASE :
               (code == REQ_DIN || code == REQ_DOUT) ? REG_DATA : REG_STATUS;
    endfunction

endpackage

// File: rtl/ide_req_server_arb.sv
// ide_rr_arb2: two-requester round-robin arbiter; the port served last loses a tie
module ide_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       latch,
    output logic       pick,
    output logic       port
);

    logic last;

    assign pick = &req ? ~last : req[1];

    always_ff @(posedge clk)
        if (reset) begin
            last <= 1'b1;
            port <= 1'b0;
        end else if (latch && |req) begin
            last <= pick;
            port <= pick;
        end

endmodule

// File: rtl/ide_req_server.sv
// ide_req_server: serves one pending IDE port request at a time between the management port and host streams
module ide_req_server
    import ide_req_pkg::*;
#(
    parameter int SECTOR_WORDS = 256,
    parameter int TF_WORDS     = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  ide_req,
    output logic [4:0]  ide_address,
    output logic        ide_write,
    output logic [15:0] ide_writedata,
    output logic        ide_read,
    input  logic [15:0] ide_readdata,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        busy
);

    function automatic logic [8:0] target(input logic [2:0] c);
        return c == REQ_CMD ? 9'(TF_WORDS) :
               (c == REQ_DIN || c == REQ_DOUT) ? 9'(SECTOR_WORDS) : 9'd0;
    endfunction

    state_t      state;
    logic [2:0]  code;
    logic [8:0]  cnt;
    logic        gap;
    logic [15:0] data_q;
    logic        pick;
    logic        port;
    logic [1:0]  pend;
    logic [2:0]  arb_code;
    logic        last_word;
    logic [3:0]  rd_next;

    assign pend      = {ide_req[5:3] != REQ_NONE, ide_req[2:0] != REQ_NONE};
    assign arb_code  = pick ? ide_req[5:3] : ide_req[2:0];
    assign last_word = cnt + 9'd1 == target(code);
    // Next read register is set up one cycle ahead so the address is settled before the strobe
    assign rd_next   = last_word ? REG_STATUS :
                       code == REQ_CMD ? REG_TF_BASE + cnt[3:0] + 4'd1 : REG_DATA;
    assign out_data  = state == S_RD_CAP ? ide_readdata : data_q;
    assign busy      = state != S_IDLE;

    ide_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (pend),
        .latch (state == S_ARB),
        .pick  (pick),
        .port  (port)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            code          <= REQ_NONE;
            cnt           <= '0;
            gap           <= 1'b0;
            data_q        <= '0;
            ide_address   <= '0;
            ide_write     <= 1'b0;
            ide_writedata <= '0;
            ide_read      <= 1'b0;
            out_valid     <= 1'b0;
            in_ready      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (|pend) state <= S_ARB;
                S_ARB: begin
                    if (|pend) begin
                        code        <= arb_code;
                        data_q      <= hdr_word(pick, arb_code, 12'(target(arb_code)));
                        out_valid   <= 1'b1;
                        ide_address <= {pick, first_reg(arb_code)};
                        state       <= S_HDR;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HDR: begin
                    cnt <= '0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (code == REQ_CMD || code == REQ_DOUT) begin
                            ide_read <= 1'b1;
                            state    <= S_RD_ISSUE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= code == REQ_DIN ? S_WR_WAIT : S_STAT_WAIT;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    ide_read    <= 1'b0;
                    ide_address <= {port, rd_next};
                    out_valid   <= 1'b1;
                    state       <= S_RD_CAP;
                end
                S_RD_CAP, S_RD_HOLD: begin
                    if (state == S_RD_CAP) data_q <= ide_readdata;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= cnt + 9'd1;
                        in_ready  <= last_word;
                        ide_read  <= ~last_word;
                        state     <= last_word ? S_STAT_WAIT : S_RD_ISSUE;
                    end else begin
                        state <= S_RD_HOLD;
                    end
                end
                S_WR_WAIT, S_STAT_WAIT: begin
                    if (in_valid) begin
                        ide_writedata <= in_data;
                        ide_write     <= 1'b1;
                        in_ready      <= 1'b0;
                        state         <= state == S_WR_WAIT ? S_WR_ISSUE : S_STAT_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    ide_write <= 1'b0;
                    cnt       <= cnt + 9'd1;
                    in_ready  <= 1'b1;
                    if (last_word) ide_address <= {port, REG_STATUS};
                    state     <= last_word ? S_STAT_WAIT : S_WR_WAIT;
                end
                S_STAT_ISSUE: begin
                    ide_write <= 1'b0;
                    gap       <= 1'b0;
                    state     <= S_GAP;
                end
                S_GAP: begin
                    gap <= 1'b1;
                    if (gap) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ide_req_server.sv
// tb_ide_req_server: randomized bench with a queue-based request model and per-cycle checking
module tb_ide_req_server;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  ide_req = '0;
    logic [4:0]  ide_address;
    logic        ide_write;
    logic [15:0] ide_writedata;
    logic        ide_read;
    logic [15:0] ide_readdata = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        busy;

    ide_req_server dut (
        .clk           (clk),
        .reset         (reset),
        .ide_req       (ide_req),
        .ide_address   (ide_address),
        .ide_write     (ide_write),
        .ide_writedata (ide_writedata),
        .ide_read      (ide_read),
        .ide_readdata  (ide_readdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int compared = 0, mismatched = 0, cyc = 0, wr7 = 0, wr7_cyc = 0, fall_cyc = 0;
    bit rnd = 0, took = 0, pv_stall = 0, pv_read = 0, pv_busy = 0, last = 1;
    logic [15:0] pv_data = '0;
    logic [4:0]  pv_addr = '0;
    logic [15:0] exp_out[$], host_q[$], dq[$], got_out[$];
    logic [20:0] exp_wr[$], got_wr[$];
    logic [4:0]  exp_rd[$];
    logic [15:0] tf[2][8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive host/controller inputs at the negedge, then check this cycle's outputs
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        cyc++;
        if (took) begin
            host_q.delete(0);
            in_valid = 1'b0;
            took = 0;
        end
        if (!in_valid && host_q.size() > 0 && (!rnd || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_data  = host_q[0];
        end
        out_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
        if (ide_read) begin
            if (ide_address[3:0] != 4'd0) ide_readdata = tf[ide_address[4]][ide_address[2:0]];
            else if (dq.size() > 0) ide_readdata = dq.pop_front();
            else ide_readdata = 16'hdead;
        end
        if (pv_stall && !reset) begin
            chk("out_hold_valid", 32'(out_valid), 32'd1);
            chk("out_hold_data", 32'(out_data), 32'(pv_data));
        end
        if (out_valid && out_ready) begin
            got_out.push_back(out_data);
            e = exp_out.size() > 0 ? 32'(exp_out.pop_front()) : 32'hxxxxxxxx;
            chk("out_word", 32'(out_data), e);
        end
        if (ide_read) begin
            chk("read_single_cycle", 32'(pv_read), 32'd0);
            chk("read_addr_setup", 32'(ide_address), 32'(pv_addr));
            e = exp_rd.size() > 0 ? 32'(exp_rd.pop_front()) : 32'hxxxxxxxx;
            chk("read_addr", 32'(ide_address), e);
        end
        if (ide_write) begin
            chk("write_in_ready_low", 32'(in_ready), 32'd0);
            chk("write_addr_setup", 32'(ide_address), 32'(pv_addr));
            got_wr.push_back({ide_address, ide_writedata});
            e = exp_wr.size() > 0 ? 32'(exp_wr.pop_front()) : 32'hxxxxxxxx;
            chk("write_addr_data", 32'({ide_address, ide_writedata}), e);
            if (ide_address[3:0] == 4'd7) begin
                wr7++;
                wr7_cyc = cyc;
                if (ide_address[4]) ide_req[5:3] = 3'd0;
                else ide_req[2:0] = 3'd0;
            end
        end
        if (in_valid && in_ready) took = 1;
        if (pv_busy && !busy) fall_cyc = cyc;
        pv_stall = out_valid && !out_ready;
        pv_data  = out_data;
        pv_read  = ide_read;
        pv_addr  = ide_address;
        pv_busy  = busy;
    endtask

    // Expected traffic for one request, derived from the request code alone
    task automatic plan(input int p, input logic [2:0] c, input logic [15:0] st, input bit seq);
        int n;
        logic [15:0] w;
        n = c == 3'd1 ? 6 : (c == 3'd2 || c == 3'd3) ? 256 : 0;
        exp_out.push_back(16'(p * 32768 + int'(c) * 4096 + n));
        for (int i = 0; i < n; i++) begin
            if (c == 3'd1) begin
                exp_rd.push_back(5'(p * 16 + 1 + i));
                exp_out.push_back(tf[p][1 + i]);
            end else if (c == 3'd2) begin
                w = seq ? 16'(i) : 16'($urandom);
                host_q.push_back(w);
                exp_wr.push_back({5'(p * 16), w});
            end else begin
                w = 16'($urandom);
                dq.push_back(w);
                exp_rd.push_back(5'(p * 16));
                exp_out.push_back(w);
            end
        end
        host_q.push_back(st);
        exp_wr.push_back({5'(p * 16 + 7), st});
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic batch(input logic [2:0] c0, input logic [2:0] c1, input logic [15:0] s0,
                         input logic [15:0] s1, input bit seq);
        int k;
        bit f;
        got_out.delete();
        got_wr.delete();
        if (c0 != 0 && c1 != 0) begin
            f = !last;
            plan(int'(f), f ? c1 : c0, f ? s1 : s0, seq);
            plan(int'(!f), f ? c0 : c1, f ? s0 : s1, seq);
            last = !f;
        end else begin
            f = c1 != 0;
            plan(int'(f), f ? c1 : c0, f ? s1 : s0, seq);
            last = f;
        end
        ide_req = {c1, c0};
        k = 0;
        do begin
            tick();
            k++;
        end while ((ide_req != 0 || busy || exp_out.size() + exp_wr.size() + exp_rd.size() != 0) && k < 4000);
        if (k >= 4000) begin
            chk("batch_pending", 32'(exp_out.size() + exp_wr.size() + exp_rd.size() + int'(busy)), 32'd0);
            finish_run();
        end
    endtask

    task automatic flush();
        exp_out.delete();
        exp_wr.delete();
        exp_rd.delete();
        host_q.delete();
        dq.delete();
        in_valid = 1'b0;
        took = 0;
        ide_req = '0;
    endtask

    task automatic chk_rst();
        chk("rst_ide_address", 32'(ide_address), 32'd0);
        chk("rst_ide_write", 32'(ide_write), 32'd0);
        chk("rst_ide_read", 32'(ide_read), 32'd0);
        chk("rst_ide_writedata", 32'(ide_writedata), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        flush();
        reset = 1'b1;
        tick();
        chk_rst();
        reset = 1'b0;
        last = 1;
        tick();
    endtask

    initial begin
        int k, w;
        logic [2:0] c0, c1;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 8; r++) tf[p][r] = 16'($urandom);
        tick();
        do_reset();

        batch(3'd1, 3'd0, 16'h0050, 16'h0000, 0);
        chk("t1_header", 32'(got_out[0]), 32'h1006);
        chk("t1_words", 32'(got_out.size()), 32'd7);
        chk("t1_status", 32'(got_wr[0]), 32'({5'h07, 16'h0050}));
        chk("t1_busy_after_status", 32'(fall_cyc - wr7_cyc), 32'd3);

        batch(3'd0, 3'd2, 16'h0000, 16'h0058, 1);
        chk("t2_header", 32'(got_out[0]), 32'hA100);
        chk("t2_writes", 32'(got_wr.size()), 32'd257);
        chk("t2_word255", 32'(got_wr[255]), 32'({5'h10, 16'h00FF}));
        chk("t2_status", 32'(got_wr[256]), 32'({5'h17, 16'h0058}));

        rnd = 1;
        batch(3'd3, 3'd0, 16'h1234, 16'h0000, 0);
        rnd = 0;
        chk("t3_header", 32'(got_out[0]), 32'h3100);
        chk("t3_words", 32'(got_out.size()), 32'd257);

        do_reset();
        batch(3'd1, 3'd1, 16'h0011, 16'h0022, 0);
        chk("t4_first_port0", 32'(got_out[0]), 32'h1006);
        chk("t4_second_port1", 32'(got_out[7]), 32'h9006);
        batch(3'd1, 3'd1, 16'h0033, 16'h0044, 0);
        chk("t4_again_port0", 32'(got_out[0]), 32'h1006);

        got_out.delete();
        plan(0, 3'd3, 16'h7777, 0);
        ide_req = 6'o03;
        k = 0;
        do begin
            tick();
            k++;
        end while (got_out.size() < 101 && k < 2000);
        chk("t5_reached_word100", 32'(got_out.size() >= 101), 32'd1);
        w = wr7;
        flush();
        reset = 1'b1;
        tick();
        chk_rst();
        reset = 1'b0;
        last = 1;
        repeat (20) tick();
        chk("t5_no_status_write", 32'(wr7), 32'(w));
        chk("t5_idle", 32'(busy), 32'd0);

        batch(3'd0, 3'd6, 16'h0000, 16'h00AA, 0);
        chk("t6_header", 32'(got_out[0]), 32'hE000);
        chk("t6_writes", 32'(got_wr.size()), 32'd1);
        chk("t6_status_addr", 32'(got_wr[0][20:16]), 32'h17);

        repeat (6) begin
            c0 = 3'($urandom_range(7));
            c1 = 3'($urandom_range(7));
            if (c0 == 0 && c1 == 0) c0 = 3'd1;
            rnd = $urandom_range(1) != 0;
            batch(c0, c1, 16'($urandom), 16'($urandom), 0);
        end
        rnd = 0;
        finish_run();
    end

endmodule
